// File: rtl/muldiv_unit_if.sv
// Handshake and operand bundle between the execute stage and the iterative
// multiply/divide unit.
interface muldiv_unit_if #(
    parameter int XLEN = 32
);
    logic            start;
    logic [2:0]      func;
    logic [XLEN-1:0] din1;
    logic [XLEN-1:0] din2;
    logic            flush;
    logic            busy;
    logic            done;
    logic [XLEN-1:0] dout;

    modport master (
        output start, func, din1, din2, flush,
        input  busy, done, dout
    );

    modport slave (
        input  start, func, din1, din2, flush,
        output busy, done, dout
    );
endinterface

// File: rtl/muldiv_unit.sv
// Iterative RV32M multiply/divide unit: a radix-2 shift-add multiplier and a
// restoring divider sharing one 2*XLEN-bit accumulator.
module muldiv_unit #(
    parameter int XLEN = 32
) (
    input  logic         clk,
    input  logic         rst,
    muldiv_unit_if.slave bus
);
    localparam int CNT_W = $clog2(XLEN) + 1;

    typedef enum logic [1:0] {IDLE, CALC, FIX, DONE} state_t;

    state_t            state_q, state_d;
    logic [CNT_W-1:0]  cnt_q, cnt_d;
    logic [2*XLEN-1:0] acc_q, acc_d;
    logic [XLEN-1:0]   opA_q, opA_d;
    logic [2:0]        func_q, func_d;
    logic              negRes_q, negRes_d;
    logic [XLEN-1:0]   dout_q, dout_d;

    logic            isDivIn;
    logic            signA;
    logic            signB;
    logic            divByZero;
    logic            divOverflow;
    logic [XLEN-1:0] magA;
    logic [XLEN-1:0] magB;

    // MULHSU treats only rs1 as signed; MUL needs no sign handling since its low half is sign-agnostic.
    assign isDivIn     = bus.func[2];
    assign signA       = bus.din1[XLEN-1] & ((bus.func == 3'b001) || (bus.func == 3'b010) ||
                                             (bus.func == 3'b100) || (bus.func == 3'b110));
    assign signB       = bus.din2[XLEN-1] & ((bus.func == 3'b001) || (bus.func == 3'b100) ||
                                             (bus.func == 3'b110));
    assign magA        = signA ? -bus.din1 : bus.din1;
    assign magB        = signB ? -bus.din2 : bus.din2;
    assign divByZero   = isDivIn && (bus.din2 == '0);
    assign divOverflow = isDivIn && !bus.func[0] &&
                         (bus.din1 == {1'b1, {(XLEN-1){1'b0}}}) && (bus.din2 == '1);

    logic [XLEN:0]     mulSum;
    logic [XLEN:0]     divTrial;
    logic [XLEN:0]     divDiff;
    logic [2*XLEN-1:0] mulNext;
    logic [2*XLEN-1:0] divNext;
    logic [2*XLEN-1:0] prodFix;
    logic [XLEN-1:0]   divRes;
    logic [XLEN-1:0]   divFix;

    // Multiply keeps the multiplier in the low half and shifts right; divide
    // keeps the dividend/quotient in the low half and shifts left.
    assign mulSum   = {1'b0, acc_q[2*XLEN-1:XLEN]} + ({1'b0, opA_q} & {(XLEN+1){acc_q[0]}});
    assign mulNext  = {mulSum, acc_q[XLEN-1:1]};
    assign divTrial = acc_q[2*XLEN-1:XLEN-1];
    assign divDiff  = divTrial - {1'b0, opA_q};
    assign divNext  = divDiff[XLEN] ? {divTrial[XLEN-1:0], acc_q[XLEN-2:0], 1'b0}
                                    : {divDiff[XLEN-1:0],  acc_q[XLEN-2:0], 1'b1};
    assign prodFix  = negRes_q ? -acc_q : acc_q;
    assign divRes   = func_q[1] ? acc_q[2*XLEN-1:XLEN] : acc_q[XLEN-1:0];
    assign divFix   = negRes_q ? -divRes : divRes;

    always_comb begin
        state_d  = state_q;
        cnt_d    = cnt_q;
        acc_d    = acc_q;
        opA_d    = opA_q;
        func_d   = func_q;
        negRes_d = negRes_q;
        dout_d   = dout_q;
        unique case (state_q)
            IDLE: begin
                if (bus.start && !bus.flush) begin
                    func_d = bus.func;
                    cnt_d  = '0;
                    if (isDivIn) begin
                        opA_d    = magB;
                        acc_d    = {{XLEN{1'b0}}, magA};
                        negRes_d = bus.func[1] ? signA : (signA ^ signB);
                    end else begin
                        opA_d    = magA;
                        acc_d    = {{XLEN{1'b0}}, magB};
                        negRes_d = signA ^ signB;
                    end
                    if (divByZero) begin
                        dout_d  = bus.func[1] ? bus.din1 : '1;
                        state_d = DONE;
                    end else if (divOverflow) begin
                        dout_d  = bus.func[1] ? '0 : bus.din1;
                        state_d = DONE;
                    end else begin
                        state_d = CALC;
                    end
                end
            end
            CALC: begin
                if (bus.flush) begin
                    state_d = IDLE;
                end else begin
                    acc_d = func_q[2] ? divNext : mulNext;
                    cnt_d = cnt_q + CNT_W'(1);
                    if (cnt_q == CNT_W'(XLEN - 1)) begin
                        state_d = FIX;
                    end
                end
            end
            FIX: begin
                if (bus.flush) begin
                    state_d = IDLE;
                end else begin
                    if (func_q[2]) begin
                        dout_d = divFix;
                    end else if (func_q[1:0] == 2'b00) begin
                        dout_d = prodFix[XLEN-1:0];
                    end else begin
                        dout_d = prodFix[2*XLEN-1:XLEN];
                    end
                    state_d = DONE;
                end
            end
            DONE: begin
                state_d = IDLE;
            end
            default: begin
                state_d = IDLE;
            end
        endcase
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q  <= IDLE;
            cnt_q    <= '0;
            acc_q    <= '0;
            opA_q    <= '0;
            func_q   <= '0;
            negRes_q <= 1'b0;
            dout_q   <= '0;
        end else begin
            state_q  <= state_d;
            cnt_q    <= cnt_d;
            acc_q    <= acc_d;
            opA_q    <= opA_d;
            func_q   <= func_d;
            negRes_q <= negRes_d;
            dout_q   <= dout_d;
        end
    end

    assign bus.busy = (state_q == CALC) || (state_q == FIX);
    assign bus.done = (state_q == DONE);
    assign bus.dout = dout_q;
endmodule

// File: doc/muldiv_unit.md
Name: muldiv_unit

Overview:
- Iterative RV32M multiply/divide unit, parametrised in operand width.
- Sits beside the single-cycle ALU in the execute stage. The ALU continues to handle base integer ops.
- Executes all eight M-extension ops (MUL, MULH, MULHSU, MULHU, DIV, DIVU, REM, REMU) with a start/busy/done handshake, so the pipeline stalls on busy instead of relying on a combinational multiplier.
- Radix-2 shift-add multiplier and restoring divider share one accumulator datapath.

Parameters:
- XLEN, 32, operand and result width; any even value ≥ 8.
- CNT_W, $clog2(XLEN)+1, iteration counter width (derived; not overridden).

Ports:
- clk  in  1  system clock, rising edge.
- rst  in  1  reset, asynchronous, active-high.
- start  in  1  request pulse; accepted only in IDLE.
- func  in  3  op select: 000 MUL, 001 MULH, 010 MULHSU, 011 MULHU, 100 DIV, 101 DIVU, 110 REM, 111 REMU.
- din1  in  XLEN  rs1 operand (multiplicand / dividend).
- din2  in  XLEN  rs2 operand (multiplier / divisor).
- flush  in  1  synchronous abort (branch mispredict / trap).
- busy  out  1  high while an op is in flight (CALC or FIX).
- done  out  1  one-cycle pulse; dout is valid in this cycle.
- dout  out  XLEN  result register.

Behaviour:
- Reset: state=IDLE, busy=0, done=0, dout=0, counter=0, all internal registers 0. Reset may be asserted at any time, including mid-operation, and then takes effect immediately.
- FSM states: IDLE, CALC, FIX, DONE.
- IDLE:
  - On start=1, func, din1 and din2 are latched at edge E0.
  - Signed ops (MULH, MULHSU for din1 only, DIV, REM) convert negative operands to magnitudes. Result-sign flags are recorded.
  - Next state is CALC with counter=0, unless a special case applies (see below).
- Special cases, decided in IDLE, go directly to DONE with the result loaded at E0 (latency 1):
  - Divisor=0: DIV/DIVU give all ones; REM/REMU give din1.
  - Signed overflow (DIV/REM with din1=100..0, din2=all ones): DIV gives din1; REM gives 0.
- CALC: one iteration per edge for XLEN edges (E1..E_XLEN). The counter increments each edge; FIX is entered when counter reaches XLEN-1.
  - Multiply: 2*XLEN-bit product accumulator, add-and-shift on LSB of the multiplier.
  - Divide: restoring; shift remainder left, trial subtract, set quotient bit.
- FIX (edge E_XLEN+1):
  - Apply two's-complement sign correction.
  - MUL selects the low XLEN bits; MULH/MULHSU/MULHU select the high XLEN bits.
  - Quotient takes sign of din1 XOR sign of din2. Remainder takes sign of din1.
  - The result is written to dout and the FSM goes to DONE.
- DONE: done=1 for exactly one cycle, then IDLE. dout holds its value until the next result load.
- busy is 1 in CALC and FIX, and 0 in IDLE and DONE. Normal latency: done is high in the cycle after edge E0+XLEN+1, i.e. XLEN+2 cycles from start.
- start while not in IDLE is ignored: no queueing, no effect on the in-flight op.
- start in the DONE cycle is also ignored. The earliest back-to-back start is the cycle after done.
- flush=1 in CALC or FIX: next state IDLE, busy drops next cycle, no done pulse, dout unchanged.
- flush in IDLE or DONE has no effect; the DONE pulse still completes.
- flush and start together in IDLE: flush wins and start is dropped.
- din1/din2/func may change freely after E0; only the latched copies are used.

Test Plan:
- Reset mid-CALC: start DIVU 100/7, assert rst at cycle 10 → busy=0, done=0, dout=0 immediately; a new start after release works normally.
- MUL/MULH: start MULH din1=0xFFFFFFFF (-1), din2=0x00000002 → done at cycle 34, dout=0xFFFFFFFF; MUL on the same operands → 0xFFFFFFFE; MULHU → 0x00000001; MULHSU → 0xFFFFFFFF.
- Signed divide: DIV -7/2 → 0xFFFFFFFD (-3); REM -7/2 → 0xFFFFFFFF (-1); DIVU 7/2 → 3, REMU → 1; each op has busy high for exactly 33 cycles.
- Special cases: DIV x/0 with x=0x12345678 → 0xFFFFFFFF, and REMU → 0x12345678. DIV 0x80000000/0xFFFFFFFF → 0x80000000, and REM → 0. All four give done 1 cycle after start and busy never high.
- Handshake: a start pulse at cycles 5 and 20 during a busy op is ignored and yields one done only. flush at cycle 15 → no done, dout retains the prior result. A start the cycle after done is accepted.
- Parameter sweep: XLEN=8 and XLEN=16, random operands against a reference model for all eight funcs; latency = XLEN+2 cycles.
